// File: rtl/wb_pkg.sv
// -----------------------------------------------------------------------------
// wb_pkg
// Shared constants and types for the writeback merge stage (wb_arbiter).
//
// Contents:
//   SRC_ALU / SRC_LSU / SRC_MDU : default source indices of the functional units
//   REG_ADDR_W                  : integer register address width
//   WB_DATA_W_DEFAULT           : default result width
//   wb_entry_t                  : {rd, data} result record at the default width
//   wb_next_src()               : round-robin successor of a source index
// -----------------------------------------------------------------------------
package wb_pkg;

    localparam int SRC_ALU           = 0;
    localparam int SRC_LSU           = 1;
    localparam int SRC_MDU           = 2;
    localparam int REG_ADDR_W        = 5;
    localparam int WB_DATA_W_DEFAULT = 32;

    // One buffered result. The RTL stores entries as flat {rd, data} vectors so
    // that DATA_WIDTH can be overridden; this struct documents the default layout.
    typedef struct packed {
        logic [REG_ADDR_W-1:0]        rd;
        logic [WB_DATA_W_DEFAULT-1:0] data;
    } wb_entry_t;

    // Successor of source index 'cur' among 'num' sources, wrapping to 0.
    function automatic int wb_next_src(input int cur, input int num);
        return (cur + 1 >= num) ? 0 : cur + 1;
    endfunction

endpackage

// File: rtl/wb_src_fifo.sv
// -----------------------------------------------------------------------------
// wb_src_fifo
// Per-source result buffer for wb_arbiter. Small circular FIFO with a
// registered occupancy count; full/empty come straight from that count so the
// upstream ready has no combinational dependency on push or pop.
//
// Parameters:
//   DEPTH : entries (power of two, >= 2)
//   WIDTH : entry width in bits
//
// Ports:
//   clk      in   clock
//   rst_n    in   asynchronous active-low reset (FIFO empties)
//   flush_i  in   synchronous clear; blocks push and pop that cycle
//   push_i   in   write din_i (ignored when full)
//   din_i    in   entry to write
//   pop_i    in   discard head entry (ignored when empty)
//   dout_o   out  head entry (valid while !empty_o)
//   full_o   out  count == DEPTH
//   empty_o  out  count == 0
// -----------------------------------------------------------------------------
module wb_src_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 37
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign dout_o  = mem_q[rd_ptr_q];

    // A full FIFO refuses the push even if it is popped in the same cycle.
    assign push_ok = push_i && !full_o && !flush_i;
    assign pop_ok  = pop_i && !empty_o && !flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            // Pointers are PTR_W bits wide, so the increment wraps modulo DEPTH.
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            if (push_ok) begin
                mem_q[wr_ptr_q] <= din_i;
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter
// Writeback merge stage in front of the integer register-file write port.
// Each functional unit pushes {rd, data} results into its own wb_src_fifo over
// a valid/ready handshake; a round-robin arbiter picks one non-empty FIFO per
// cycle and the chosen result is registered onto the write port together with
// a retire pulse for the instret counter.
//
// Handshake: a result transfers on a rising edge where src_valid[i] and
// src_ready[i] are both high. src_ready[i] is !full of FIFO i and depends only
// on registered state; a producer must hold its result until it transfers.
//
// Parameters:
//   NUM_SRC    : number of result sources (2..8)
//   DATA_WIDTH : result width
//   FIFO_DEPTH : entries per source FIFO (power of two, >= 2)
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   flush         synchronous discard of every buffered result
//   src_valid     per-source result valid           [NUM_SRC]
//   src_ready     per-source FIFO not full          [NUM_SRC]
//   src_rd_addr   packed destination registers      [NUM_SRC*5], src i at [5i+4:5i]
//   src_data      packed result data                [NUM_SRC*DATA_WIDTH]
//   wb_rd_write   register-file write enable (never for x0)
//   wb_rd_addr    register-file write address
//   wb_rd_data    register-file write data
//   wb_retire     one result retired this cycle (x0 included)
//   wb_src_id     source of the current retire
//
// Build option WB_ARBITER_FWD_EN adds a combinational bypass of the write that
// the register file has not captured yet:
//   fwd_rs1_addr / fwd_rs2_addr  in   read addresses to compare
//   fwd_rs1_hit  / fwd_rs2_hit   out  address matches a live non-x0 write
//   fwd_rs1_data / fwd_rs2_data  out  the write data
// -----------------------------------------------------------------------------
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int NUM_SRC    = 3,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic [NUM_SRC-1:0]            src_valid,
    output logic [NUM_SRC-1:0]            src_ready,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] src_rd_addr,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
    output logic                          wb_rd_write,
    output logic [REG_ADDR_W-1:0]         wb_rd_addr,
    output logic [DATA_WIDTH-1:0]         wb_rd_data,
    output logic                          wb_retire,
`ifdef WB_ARBITER_FWD_EN
    input  logic [REG_ADDR_W-1:0]         fwd_rs1_addr,
    input  logic [REG_ADDR_W-1:0]         fwd_rs2_addr,
    output logic                          fwd_rs1_hit,
    output logic                          fwd_rs2_hit,
    output logic [DATA_WIDTH-1:0]         fwd_rs1_data,
    output logic [DATA_WIDTH-1:0]         fwd_rs2_data,
`endif
    output logic [$clog2(NUM_SRC)-1:0]    wb_src_id
);

    localparam int SRC_W = $clog2(NUM_SRC);
    localparam int ENT_W = REG_ADDR_W + DATA_WIDTH;

    // ------------------------------------------------------------------------
    // Source FIFOs
    // ------------------------------------------------------------------------
    logic [NUM_SRC-1:0] full_vec;
    logic [NUM_SRC-1:0] empty_vec;
    logic [NUM_SRC-1:0] pop_vec;
    logic [ENT_W-1:0]   head [NUM_SRC];

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        wb_src_fifo #(
            .DEPTH (FIFO_DEPTH),
            .WIDTH (ENT_W)
        ) u_fifo (
            .clk     (clk),
            .rst_n   (rst_n),
            .flush_i (flush),
            .push_i  (src_valid[g]),
            .din_i   ({src_rd_addr[g*REG_ADDR_W +: REG_ADDR_W],
                       src_data[g*DATA_WIDTH +: DATA_WIDTH]}),
            .pop_i   (pop_vec[g]),
            .dout_o  (head[g]),
            .full_o  (full_vec[g]),
            .empty_o (empty_vec[g])
        );
    end

    assign src_ready = ~full_vec;

    // ------------------------------------------------------------------------
    // Round-robin arbitration: first non-empty FIFO at or after rr_q, wrapping.
    // ------------------------------------------------------------------------
    logic [SRC_W-1:0] rr_q, rr_d;
    logic             grant_vld;
    logic [SRC_W-1:0] grant_idx;
    logic [ENT_W-1:0] grant_ent;
    logic             take;

    always_comb begin
        int idx;
        idx       = 0;
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= NUM_SRC) idx = idx - NUM_SRC;
            if (!grant_vld && !empty_vec[idx]) begin
                grant_vld = 1'b1;
                grant_idx = SRC_W'(idx);
            end
        end
    end

    assign grant_ent = head[grant_idx];

    // flush pops nothing and leaves the pointer where it was.
    assign take = grant_vld && !flush;

    always_comb begin
        pop_vec = '0;
        rr_d    = rr_q;
        if (take) begin
            pop_vec[grant_idx] = 1'b1;
            rr_d               = SRC_W'(wb_next_src(int'(grant_idx), NUM_SRC));
        end
    end

    // ------------------------------------------------------------------------
    // Registered write port. Address, data and source id hold between retires.
    // ------------------------------------------------------------------------
    logic                  wr_q,     wr_d;
    logic                  retire_q, retire_d;
    logic [REG_ADDR_W-1:0] addr_q,   addr_d;
    logic [DATA_WIDTH-1:0] data_q,   data_d;
    logic [SRC_W-1:0]      src_q,    src_d;

    always_comb begin
        wr_d     = 1'b0;
        retire_d = 1'b0;
        addr_d   = addr_q;
        data_d   = data_q;
        src_d    = src_q;
        if (take) begin
            retire_d = 1'b1;
            src_d    = grant_idx;
            addr_d   = grant_ent[ENT_W-1 -: REG_ADDR_W];
            data_d   = grant_ent[DATA_WIDTH-1:0];
            // x0 results still retire but never write the register file.
            wr_d     = (grant_ent[ENT_W-1 -: REG_ADDR_W] != '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q     <= '0;
            wr_q     <= 1'b0;
            retire_q <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            src_q    <= '0;
        end else begin
            rr_q     <= rr_d;
            wr_q     <= wr_d;
            retire_q <= retire_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            src_q    <= src_d;
        end
    end

    assign wb_rd_write = wr_q;
    assign wb_retire   = retire_q;
    assign wb_rd_addr  = addr_q;
    assign wb_rd_data  = data_q;
    assign wb_src_id   = src_q;

    // ------------------------------------------------------------------------
    // Optional bypass of the write the register file captures at the next edge.
    // ------------------------------------------------------------------------
`ifdef WB_ARBITER_FWD_EN
    assign fwd_rs1_hit  = wr_q && (fwd_rs1_addr == addr_q) && (fwd_rs1_addr != '0);
    assign fwd_rs2_hit  = wr_q && (fwd_rs2_addr == addr_q) && (fwd_rs2_addr != '0);
    assign fwd_rs1_data = data_q;
    assign fwd_rs2_data = data_q;
`else
    // No bypass ports; consumers read the register file after the write lands.
`endif

endmodule
